// File: rtl/reg_file_8x.sv
// Eight-entry register file: one-hot write select, two registered read ports, 1-cycle read latency.
// No backpressure; malformed write selects are dropped and flagged on the sticky wr_err.
module reg_file_8x #(
  parameter int WIDTH = 16,
  parameter int NREG  = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [NREG-1:0]  wr_sel,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b,
  output logic             rd_valid,
  output logic             wr_err,
  input  logic             err_clr
);

  logic [WIDTH-1:0] regs_q [NREG];
  logic [WIDTH-1:0] regs_d [NREG];
  logic [WIDTH-1:0] rd_data_a_q, rd_data_a_d;
  logic [WIDTH-1:0] rd_data_b_q, rd_data_b_d;
  logic             rd_valid_q, rd_valid_d;
  logic             wr_err_q, wr_err_d;
  logic             sel_onehot;
  logic             wr_ok;
  logic             wr_bad;

  always_comb begin
    sel_onehot = (wr_sel != '0) && ((wr_sel & (wr_sel - NREG'(1))) == '0);
    wr_ok      = wr_en && sel_onehot;
    wr_bad     = wr_en && !sel_onehot;

    for (int i = 0; i < NREG; i++) begin
      regs_d[i] = (wr_ok && wr_sel[i]) ? wr_data : regs_q[i];
    end

    // Reading the next-state array gives write-through for free; a dropped write leaves it unchanged.
    rd_valid_d  = rd_en;
    rd_data_a_d = rd_en ? regs_d[rd_addr_a] : rd_data_a_q;
    rd_data_b_d = rd_en ? regs_d[rd_addr_b] : rd_data_b_q;

    // Set dominates clear when both happen on the same edge.
    wr_err_d = wr_bad | (wr_err_q & ~err_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      rd_data_a_q <= '0;
      rd_data_b_q <= '0;
      rd_valid_q  <= 1'b0;
      wr_err_q    <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= regs_d[i];
      end
      rd_data_a_q <= rd_data_a_d;
      rd_data_b_q <= rd_data_b_d;
      rd_valid_q  <= rd_valid_d;
      wr_err_q    <= wr_err_d;
    end
  end

  assign rd_data_a = rd_data_a_q;
  assign rd_data_b = rd_data_b_q;
  assign rd_valid  = rd_valid_q;
  assign wr_err    = wr_err_q;

endmodule

// File: tb/tb_reg_file_8x.sv
// Directed bench for reg_file_8x: reset, write/read, bypass, malformed selects, error clear, fill and reset.
module tb_reg_file_8x;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [7:0]  wr_sel;
  logic [15:0] wr_data;
  logic        rd_en;
  logic [2:0]  rd_addr_a;
  logic [2:0]  rd_addr_b;
  logic [15:0] rd_data_a;
  logic [15:0] rd_data_b;
  logic        rd_valid;
  logic        wr_err;
  logic        err_clr;

  int vectors = 0;
  int errs    = 0;

  reg_file_8x #(.WIDTH(16), .NREG(8), .AW(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_sel    (wr_sel),
    .wr_data   (wr_data),
    .rd_en     (rd_en),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .rd_valid  (rd_valid),
    .wr_err    (wr_err),
    .err_clr   (err_clr)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; wr_en = 1'b0; wr_sel = 8'h00; wr_data = 16'h0000;
    rd_en = 1'b0; rd_addr_a = 3'd0; rd_addr_b = 3'd0; err_clr = 1'b0;
  endtask

  task automatic write_reg(input int idx, input logic [15:0] val);
    idle();
    wr_en = 1'b1; wr_sel = 8'h01 << idx; wr_data = val;
    tick();
    idle();
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    vectors++;
    if (rd_valid !== 1'b0 || rd_data_a !== 16'h0 || rd_data_b !== 16'h0 || wr_err !== 1'b0) begin
      errs++;
      $display("FAIL reset_state: valid=%b a=%h b=%h err=%b, expected 0 0000 0000 0", rd_valid, rd_data_a, rd_data_b, wr_err);
    end
    idle();
    rd_en = 1'b1; rd_addr_a = 3'd0; rd_addr_b = 3'd7;
    tick();
    idle();
    vectors++;
    if (rd_data_a !== 16'h0000 || rd_data_b !== 16'h0000 || rd_valid !== 1'b1 || wr_err !== 1'b0) begin
      errs++;
      $display("FAIL reset_read: a=%h b=%h valid=%b err=%b, expected 0000 0000 1 0", rd_data_a, rd_data_b, rd_valid, wr_err);
    end
  endtask

  task automatic test_write_read();
    idle();
    wr_en = 1'b1; wr_sel = 8'b0000_0100; wr_data = 16'h1234;
    tick();
    idle();
    rd_en = 1'b1; rd_addr_a = 3'd2; rd_addr_b = 3'd2;
    tick();
    idle();
    vectors++;
    if (rd_data_a !== 16'h1234 || rd_data_b !== 16'h1234 || rd_valid !== 1'b1) begin
      errs++;
      $display("FAIL write_read_same_addr: a=%h b=%h valid=%b, expected 1234 1234 1", rd_data_a, rd_data_b, rd_valid);
    end
    // No read request: valid drops, data holds.
    tick();
    vectors++;
    if (rd_valid !== 1'b0 || rd_data_a !== 16'h1234 || rd_data_b !== 16'h1234) begin
      errs++;
      $display("FAIL read_hold: valid=%b a=%h b=%h, expected 0 1234 1234", rd_valid, rd_data_a, rd_data_b);
    end
    write_reg(0, 16'hA5A5);
    rd_en = 1'b1; rd_addr_a = 3'd0; rd_addr_b = 3'd1;
    tick();
    idle();
    vectors++;
    if (rd_data_a !== 16'hA5A5 || rd_data_b !== 16'h0000) begin
      errs++;
      $display("FAIL reg0_writable: a=%h b=%h, expected a5a5 0000", rd_data_a, rd_data_b);
    end
  endtask

  task automatic test_bypass();
    write_reg(6, 16'h6666);
    wr_en = 1'b1; wr_sel = 8'b1000_0000; wr_data = 16'hBEEF;
    rd_en = 1'b1; rd_addr_a = 3'd7; rd_addr_b = 3'd6;
    tick();
    idle();
    vectors++;
    if (rd_data_a !== 16'hBEEF || rd_data_b !== 16'h6666) begin
      errs++;
      $display("FAIL bypass_port_a: a=%h b=%h, expected beef 6666", rd_data_a, rd_data_b);
    end
    wr_en = 1'b1; wr_sel = 8'b0100_0000; wr_data = 16'h7777;
    rd_en = 1'b1; rd_addr_a = 3'd2; rd_addr_b = 3'd6;
    tick();
    idle();
    vectors++;
    if (rd_data_a !== 16'h1234 || rd_data_b !== 16'h7777) begin
      errs++;
      $display("FAIL bypass_port_b: a=%h b=%h, expected 1234 7777", rd_data_a, rd_data_b);
    end
  endtask

  task automatic test_malformed();
    write_reg(0, 16'h0A0A);
    write_reg(4, 16'h4444);
    wr_en = 1'b1; wr_sel = 8'b0001_0001; wr_data = 16'hFFFF;
    rd_en = 1'b1; rd_addr_a = 3'd0; rd_addr_b = 3'd4;
    tick();
    idle();
    vectors++;
    if (rd_data_a !== 16'h0A0A || rd_data_b !== 16'h4444 || wr_err !== 1'b1) begin
      errs++;
      $display("FAIL malformed_no_bypass: a=%h b=%h err=%b, expected 0a0a 4444 1", rd_data_a, rd_data_b, wr_err);
    end
    rd_en = 1'b1; rd_addr_a = 3'd0; rd_addr_b = 3'd4;
    tick();
    idle();
    vectors++;
    if (rd_data_a !== 16'h0A0A || rd_data_b !== 16'h4444 || wr_err !== 1'b1) begin
      errs++;
      $display("FAIL malformed_unchanged: a=%h b=%h err=%b, expected 0a0a 4444 1", rd_data_a, rd_data_b, wr_err);
    end
    err_clr = 1'b1;
    tick();
    idle();
    vectors++;
    if (wr_err !== 1'b0) begin
      errs++;
      $display("FAIL err_clear: err=%b, expected 0", wr_err);
    end
    // Malformed select with wr_en low is ignored.
    wr_sel = 8'b0000_0011; wr_data = 16'hDEAD;
    rd_en = 1'b1; rd_addr_a = 3'd0; rd_addr_b = 3'd1;
    tick();
    idle();
    vectors++;
    if (wr_err !== 1'b0 || rd_data_a !== 16'h0A0A || rd_data_b !== 16'h0000) begin
      errs++;
      $display("FAIL sel_ignored_wr_en_low: err=%b a=%h b=%h, expected 0 0a0a 0000", wr_err, rd_data_a, rd_data_b);
    end
  endtask

  task automatic test_set_wins();
    wr_en = 1'b1; wr_sel = 8'h00; wr_data = 16'h5555; err_clr = 1'b1;
    tick();
    idle();
    vectors++;
    if (wr_err !== 1'b1) begin
      errs++;
      $display("FAIL set_wins: err=%b, expected 1", wr_err);
    end
    tick();
    vectors++;
    if (wr_err !== 1'b1) begin
      errs++;
      $display("FAIL err_sticky: err=%b, expected 1", wr_err);
    end
    err_clr = 1'b1;
    tick();
    idle();
    vectors++;
    if (wr_err !== 1'b0) begin
      errs++;
      $display("FAIL err_clear2: err=%b, expected 0", wr_err);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] ea, eb;
    for (int i = 0; i < 8; i++) write_reg(i, 16'(16'h0010 * i));
    for (int i = 0; i < 8; i++) begin
      rd_en = 1'b1; rd_addr_a = 3'(i); rd_addr_b = 3'(7 - i);
      tick();
      ea = 16'(16'h0010 * i);
      eb = 16'(16'h0010 * (7 - i));
      vectors++;
      if (rd_data_a !== ea || rd_data_b !== eb || rd_valid !== 1'b1) begin
        errs++;
        $display("FAIL back_to_back[%0d]: a=%h b=%h valid=%b, expected %h %h 1", i, rd_data_a, rd_data_b, rd_valid, ea, eb);
      end
    end
    idle();
  endtask

  task automatic test_fill_reset();
    // Read and write in flight when reset hits are both discarded.
    rst = 1'b1; rd_en = 1'b1; rd_addr_a = 3'd3; rd_addr_b = 3'd5;
    wr_en = 1'b1; wr_sel = 8'b0000_1000; wr_data = 16'hCAFE;
    tick();
    idle();
    vectors++;
    if (rd_valid !== 1'b0 || rd_data_a !== 16'h0 || rd_data_b !== 16'h0 || wr_err !== 1'b0) begin
      errs++;
      $display("FAIL reset_mid_read: valid=%b a=%h b=%h err=%b, expected 0 0000 0000 0", rd_valid, rd_data_a, rd_data_b, wr_err);
    end
    for (int i = 0; i < 8; i++) begin
      rd_en = 1'b1; rd_addr_a = 3'(i); rd_addr_b = 3'(7 - i);
      tick();
      vectors++;
      if (rd_data_a !== 16'h0 || rd_data_b !== 16'h0 || rd_valid !== 1'b1) begin
        errs++;
        $display("FAIL post_reset_read[%0d]: a=%h b=%h valid=%b, expected 0000 0000 1", i, rd_data_a, rd_data_b, rd_valid);
      end
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_write_read();
    test_bypass();
    test_malformed();
    test_set_wins();
    test_back_to_back();
    test_fill_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
